mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous 16-bit memory between two requesters: requester 0 is the instruction-fetch side of mem_controller, requester 1 is the load/store/loader side.
- Uses a round-robin req/gnt/rvalid handshake and sequences each access through a small FSM.
- Sits between the processor's multicycle controller and the memory array.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two requesters.
// Each access is sequenced IDLE -> ACC (-> RESP for reads) -> IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_grant,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t st;
  logic   sel_q;
  logic   pick;

  // On contention the requester that was not granted last time wins.
  always_comb begin
    pick = 1'b0;
    if (r0_req && r1_req) pick = ~last_grant;
    else if (r1_req)      pick = 1'b1;
  end

  assign busy  = (st != IDLE);
  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      sel_q      <= 1'b0;
      last_grant <= 1'b1;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      case (st)
        IDLE: begin
          if (r0_req || r1_req) begin
            sel_q      <= pick;
            last_grant <= pick;
            r0_gnt     <= ~pick;
            r1_gnt     <= pick;
            mem_en     <= 1'b1;
            mem_we     <= pick ? r1_we    : r0_we;
            mem_addr   <= pick ? r1_addr  : r0_addr;
            mem_wdata  <= pick ? r1_wdata : r0_wdata;
            st         <= ACC;
          end
        end
        ACC: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          st     <= mem_we ? IDLE : RESP;
        end
        RESP: begin
          if (sel_q) begin
            r1_rdata  <= mem_rdata;
            r1_rvalid <= 1'b1;
          end else begin
            r0_rdata  <= mem_rdata;
            r0_rvalid <= 1'b1;
          end
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for fairness and mid-access reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [7:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [15:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, last_grant;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant), .state(state)
  );

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        r0_req, r0_we;
    logic [7:0]  r0_addr;
    logic [15:0] r0_wdata;
    logic        r1_req, r1_we;
    logic [7:0]  r1_addr;
    logic [15:0] r1_wdata;
    logic        gnt0, gnt1, rv0, rv1, en, we;
    logic [7:0]  addr;
    logic [15:0] wdata, rd0, rd1;
    logic        busy, lg;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  // Two reset cycles, then every output must be at its reset value.
  task automatic doReset();
    @(negedge clk);
    reset = 1;
    idleInputs();
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst r0_gnt", 16'(r0_gnt), 16'h0);
    chk("rst r1_gnt", 16'(r1_gnt), 16'h0);
    chk("rst r0_rvalid", 16'(r0_rvalid), 16'h0);
    chk("rst r1_rvalid", 16'(r1_rvalid), 16'h0);
    chk("rst r0_rdata", r0_rdata, 16'h0);
    chk("rst r1_rdata", r1_rdata, 16'h0);
    chk("rst mem_en", 16'(mem_en), 16'h0);
    chk("rst mem_we", 16'(mem_we), 16'h0);
    chk("rst mem_addr", 16'(mem_addr), 16'h0);
    chk("rst mem_wdata", mem_wdata, 16'h0);
    chk("rst busy", 16'(busy), 16'h0);
    chk("rst last_grant", 16'(last_grant), 16'h1);
    chk("rst state", 16'(state), 16'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    r0_req = v.r0_req; r0_we = v.r0_we; r0_addr = v.r0_addr; r0_wdata = v.r0_wdata;
    r1_req = v.r1_req; r1_we = v.r1_we; r1_addr = v.r1_addr; r1_wdata = v.r1_wdata;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string p;
    p = $sformatf("row%0d", idx);
    chk({p, " r0_gnt"}, 16'(r0_gnt), 16'(v.gnt0));
    chk({p, " r1_gnt"}, 16'(r1_gnt), 16'(v.gnt1));
    chk({p, " r0_rvalid"}, 16'(r0_rvalid), 16'(v.rv0));
    chk({p, " r1_rvalid"}, 16'(r1_rvalid), 16'(v.rv1));
    chk({p, " mem_en"}, 16'(mem_en), 16'(v.en));
    if (v.en) begin
      chk({p, " mem_we"}, 16'(mem_we), 16'(v.we));
      chk({p, " mem_addr"}, 16'(mem_addr), 16'(v.addr));
      if (v.we) chk({p, " mem_wdata"}, mem_wdata, v.wdata);
    end
    chk({p, " r0_rdata"}, r0_rdata, v.rd0);
    chk({p, " r1_rdata"}, r1_rdata, v.rd1);
    chk({p, " busy"}, 16'(busy), 16'(v.busy));
    chk({p, " last_grant"}, 16'(last_grant), 16'(v.lg));
    chk({p, " state"}, 16'(state), 16'(v.st));
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].rst) doReset();
      @(negedge clk);
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end
  endtask

  initial begin
    reset = 1;
    idleInputs();
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[8'h10] = 16'h1234;
    mem[8'h20] = 16'hABCD;

    // rst | r0 req we addr wdata | r1 req we addr wdata | gnt0 gnt1 rv0 rv1 en we addr wdata | rd0 rd1 | busy lg st
    // r0 write 0x05=0xBEEF, then r0 read 0x05
    vecs[0]  = '{1, 1,1,8'h05,16'hBEEF, 0,0,8'h00,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,       0,1,2'd0};
    vecs[1]  = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 1,0,0,0, 1,1,8'h05,16'hBEEF, 16'h0,16'h0,       1,0,2'd1};
    vecs[2]  = '{0, 1,0,8'h05,16'h0,    0,0,8'h00,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,       0,0,2'd0};
    vecs[3]  = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 1,0,0,0, 1,0,8'h05,16'h0,    16'h0,16'h0,       1,0,2'd1};
    vecs[4]  = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,       1,0,2'd2};
    vecs[5]  = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,1,0, 0,0,8'h00,16'h0,    16'hBEEF,16'h0,    0,0,2'd0};
    // simultaneous reads: r0 wins first, r1 served in the next IDLE
    vecs[6]  = '{1, 1,0,8'h10,16'h0,    1,0,8'h20,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,       0,1,2'd0};
    vecs[7]  = '{0, 0,0,8'h00,16'h0,    1,0,8'h20,16'h0, 1,0,0,0, 1,0,8'h10,16'h0,    16'h0,16'h0,       1,0,2'd1};
    vecs[8]  = '{0, 0,0,8'h00,16'h0,    1,0,8'h20,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,       1,0,2'd2};
    vecs[9]  = '{0, 0,0,8'h00,16'h0,    1,0,8'h20,16'h0, 0,0,1,0, 0,0,8'h00,16'h0,    16'h1234,16'h0,    0,0,2'd0};
    vecs[10] = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,1,0,0, 1,0,8'h20,16'h0,    16'h1234,16'h0,    1,1,2'd1};
    vecs[11] = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h1234,16'h0,    1,1,2'd2};
    vecs[12] = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,1, 0,0,8'h00,16'h0,    16'h1234,16'hABCD, 0,1,2'd0};
    // r1 write 0xFF=0x0001 (ACC is the only busy cycle), then read it back
    vecs[13] = '{0, 0,0,8'h00,16'h0,    1,1,8'hFF,16'h0001, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,    0,1,2'd0};
    vecs[14] = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,1,0,0, 1,1,8'hFF,16'h0001, 16'h0,16'h0,       1,1,2'd1};
    vecs[15] = '{0, 0,0,8'h00,16'h0,    1,0,8'hFF,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,       0,1,2'd0};
    vecs[16] = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,1,0,0, 1,0,8'hFF,16'h0,    16'h0,16'h0,       1,1,2'd1};
    vecs[17] = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0, 0,0,8'h00,16'h0,    16'h0,16'h0,       1,1,2'd2};
    vecs[18] = '{0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,1, 0,0,8'h00,16'h0,    16'h0,16'h0001,    0,1,2'd0};

    $display("[TB] reset and table-driven sequences");
    runRows(0, 12);

    // Both requesters held high: grants must alternate r0,r1,... every 3 cycles.
    $display("[TB] fairness with both requests held");
    doReset();
    begin
      int ngnt;
      int last_cyc;
      ngnt = 0;
      last_cyc = 0;
      @(negedge clk);
      r0_req = 1; r0_we = 0; r0_addr = 8'h10;
      r1_req = 1; r1_we = 0; r1_addr = 8'h20;
      for (int c = 1; c <= 40 && ngnt < 6; c++) begin
        @(negedge clk);
        if (r0_gnt || r1_gnt) begin
          chk($sformatf("fair gnt%0d r1_gnt", ngnt), 16'(r1_gnt), 16'(ngnt % 2));
          chk($sformatf("fair gnt%0d r0_gnt", ngnt), 16'(r0_gnt), 16'((ngnt + 1) % 2));
          if (ngnt > 0) chk($sformatf("fair gnt%0d spacing", ngnt), 16'(c - last_cyc), 16'd3);
          last_cyc = c;
          ngnt++;
        end
      end
      chk("fair grant count", 16'(ngnt), 16'd6);
      idleInputs();
      repeat (4) @(negedge clk);
      chk("fair r1_rdata", r1_rdata, 16'hABCD);
      chk("fair r0_rdata", r0_rdata, 16'h1234);
    end

    // Reset in the ACC cycle of an r1 read must kill the pending response.
    $display("[TB] reset during r1 read");
    begin
      int rv_seen;
      rv_seen = 0;
      @(negedge clk);
      r1_req = 1; r1_we = 0; r1_addr = 8'h20;
      @(negedge clk);
      chk("midrst acc state", 16'(state), 16'd1);
      chk("midrst acc r1_gnt", 16'(r1_gnt), 16'd1);
      reset = 1;
      idleInputs();
      @(negedge clk);
      reset = 0;
      chk("midrst state", 16'(state), 16'd0);
      chk("midrst mem_en", 16'(mem_en), 16'd0);
      chk("midrst r1_gnt", 16'(r1_gnt), 16'd0);
      chk("midrst busy", 16'(busy), 16'd0);
      chk("midrst last_grant", 16'(last_grant), 16'd1);
      chk("midrst r1_rdata", r1_rdata, 16'h0);
      chk("midrst r0_rdata", r0_rdata, 16'h0);
      for (int c = 0; c < 4; c++) begin
        if (r1_rvalid) rv_seen++;
        @(negedge clk);
      end
      chk("midrst r1_rvalid count", 16'(rv_seen), 16'd0);
    end

    $display("[TB] r1 write then read back");
    runRows(13, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
